// File: rtl/sobel_frame_scheduler.sv
// sobel_frame_scheduler: shares one sobel_stage between two AXI-Stream pixel sources, granting whole frames round-robin
// Ports:
//   clk, rst                 single rising-edge clock, asynchronous active-high reset
//   s0_* / s1_*              source pixel streams (tdata, tvalid, tready, tlast=end-of-line, tuser=start-of-frame)
//   m_*                      granted stream towards the sobel input
//   done_in                  end-of-frame handshake pulse from the sobel output side
//   grant_id, busy           owning source (valid while busy) and STREAM/DRAIN indicator
//   frame_done               one-cycle pulse after a normally completed frame
//   err_timeout, err_format  sticky error flags, cleared only by rst
module sobel_frame_scheduler #(
    parameter int IMG_WIDTH     = 128,
    parameter int IMG_HEIGHT    = 128,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    output logic       s0_tready,
    input  logic       s0_tlast,
    input  logic       s0_tuser,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    output logic       s1_tready,
    input  logic       s1_tlast,
    input  logic       s1_tuser,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser,
    input  logic       done_in,
    output logic       grant_id,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout,
    output logic       err_format
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW   = $clog2(NPIX);
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int TW   = $clog2(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state, state_nx;
    logic          rr_last;
    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] col_cnt;
    logic [TW-1:0] timer;
    logic          req0, req1, pick, beat, last_beat, tmo, fmt_bad;

    assign req0      = s0_tvalid & s0_tuser;
    assign req1      = s1_tvalid & s1_tuser;
    // Contention goes to the source that did not win last time.
    assign pick      = (req0 & req1) ? !rr_last : req1;
    assign beat      = m_tvalid & m_tready;
    assign last_beat = beat && pix_cnt == PW'(NPIX - 1);
    assign tmo       = timer == TW'(DRAIN_TIMEOUT - 1);
    // Framing errors are flagged but the beat is still forwarded.
    assign fmt_bad   = beat && ((m_tuser != (pix_cnt == '0)) || (m_tlast != (col_cnt == CW'(IMG_WIDTH - 1))));
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req0 | req1) ? STREAM : IDLE;
            STREAM:  state_nx = last_beat ? DRAIN : STREAM;
            DRAIN:   state_nx = (done_in | tmo) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tuser   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        if (state == STREAM) begin
            m_tdata   = grant_id ? s1_tdata  : s0_tdata;
            m_tvalid  = grant_id ? s1_tvalid : s0_tvalid;
            m_tlast   = grant_id ? s1_tlast  : s0_tlast;
            m_tuser   = grant_id ? s1_tuser  : s0_tuser;
            s0_tready = !grant_id & m_tready;
            s1_tready = grant_id & m_tready;
        end else if (state == IDLE) begin
            // Drop mid-frame beats so a source resynchronises on its next SOF.
            s0_tready = s0_tvalid & !s0_tuser;
            s1_tready = s1_tvalid & !s1_tuser;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id    <= 1'b0;
            rr_last     <= 1'b1;
            pix_cnt     <= '0;
            col_cnt     <= '0;
            timer       <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            err_format  <= 1'b0;
        end else begin
            frame_done <= state == DRAIN && done_in;
            if (state == IDLE && (req0 | req1)) begin
                grant_id <= pick;
                rr_last  <= pick;
                pix_cnt  <= '0;
                col_cnt  <= '0;
                timer    <= '0;
            end
            if (state == STREAM && beat) begin
                pix_cnt <= pix_cnt + 1'b1;
                col_cnt <= (col_cnt == CW'(IMG_WIDTH - 1)) ? '0 : col_cnt + 1'b1;
            end
            if (fmt_bad) err_format <= 1'b1;
            if (state == DRAIN) timer <= timer + 1'b1;
            if (state == DRAIN && tmo && !done_in) err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// tb_sobel_frame_scheduler: directed frame scenarios for sobel_frame_scheduler on a small 8x4 image
module tb_sobel_frame_scheduler;
    localparam int W = 8, H = 4, N = W * H, TMO = 64, D = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] s0_tdata, s1_tdata, m_tdata;
    logic       s0_tvalid, s0_tready, s0_tlast, s0_tuser;
    logic       s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic       m_tvalid, m_tready, m_tlast, m_tuser;
    logic       done_in, grant_id, busy, frame_done, err_timeout, err_format;

    always #5 clk = ~clk;

    sobel_frame_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DRAIN_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .done_in(done_in), .grant_id(grant_id), .busy(busy), .frame_done(frame_done),
        .err_timeout(err_timeout), .err_format(err_format)
    );

    typedef struct {
        int n0; int n1; int skip1; bit bad; bit hold; bit rnd;
        logic [7:0] g_exp; int ng_exp; int beats; int fd; int fmt; int tmo; int drain;
    } row_t;

    row_t rows[5];
    int ntot = 0, nbad = 0;
    int left[2], skip[2], idx[2];
    int beats, hs, fd, drain, pt, viol, ng, fb, dcnt, hold_left;
    bit badf, rnd, pbusy, g;
    logic [7:0] gseq;

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive();
        logic [7:0] d[2];
        logic v[2], u[2], l[2];
        for (int k = 0; k < 2; k++) begin
            v[k] = left[k] > 0;
            u[k] = v[k] && skip[k] == 0 && idx[k] == 0;
            l[k] = v[k] && skip[k] == 0 && ((idx[k] % W) == W - 1 || (k == 0 && badf && idx[k] == 2 * W + W - 2));
            d[k] = skip[k] > 0 ? 8'hEE : 8'(idx[k]);
        end
        s0_tvalid = v[0]; s0_tuser = u[0]; s0_tlast = l[0]; s0_tdata = d[0];
        s1_tvalid = v[1]; s1_tuser = u[1]; s1_tlast = l[1]; s1_tdata = d[1];
    endtask

    task automatic adv(input int k);
        if (skip[k] > 0) skip[k]--;
        else if (idx[k] == N - 1) begin
            idx[k] = 0;
            left[k]--;
            if (k == 0) badf = 0;
        end else idx[k]++;
    endtask

    task automatic tick();
        bit h0, h1, lb;
        @(negedge clk);
        h0 = s0_tvalid & s0_tready;
        h1 = s1_tvalid & s1_tready;
        hs += int'(h0) + int'(h1);
        if (busy && !pbusy) begin
            g = grant_id;
            gseq = {gseq[6:0], g};
            ng++;
            fb = 0;
        end
        pbusy = busy;
        if (frame_done) fd++;
        if (busy && fb == N) begin
            drain++;
            if (m_tvalid | s0_tready | s1_tready) viol++;
        end
        if (busy && (g ? s0_tready : s1_tready)) viol++;
        lb = 0;
        if (m_tvalid & m_tready) begin
            beats++;
            if (m_tdata != 8'(fb) || m_tuser != (fb == 0)) pt++;
            lb = fb == N - 1;
            fb++;
        end
        @(posedge clk);
        #1;
        done_in = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                if (hold_left > 0) hold_left--;
                else done_in = 1'b1;
            end
        end
        if (lb) dcnt = D;
        if (h0) adv(0);
        if (h1) adv(1);
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
    endtask

    task automatic start(input row_t r);
        left[0] = r.n0; left[1] = r.n1;
        skip[0] = 0; skip[1] = r.skip1;
        idx[0] = 0; idx[1] = 0;
        badf = r.bad; hold_left = int'(r.hold); rnd = r.rnd;
        beats = 0; hs = 0; fd = 0; drain = 0; pt = 0; viol = 0; ng = 0;
        gseq = '0; pbusy = 0; g = 0; fb = N; dcnt = 0;
        drive();
    endtask

    task automatic run(input row_t r, input string nm);
        int t;
        start(r);
        for (t = 0; t < 3000; t++) begin
            tick();
            if (left[0] == 0 && left[1] == 0 && !pbusy && dcnt == 0) break;
        end
        chk({nm, " budget"}, int'(t < 3000), 1);
        chk({nm, " grants"}, int'(gseq), int'(r.g_exp));
        chk({nm, " ngrants"}, ng, r.ng_exp);
        chk({nm, " beats"}, beats, r.beats);
        chk({nm, " src_hs"}, hs, r.beats + r.skip1);
        chk({nm, " frame_done"}, fd, r.fd);
        chk({nm, " err_format"}, int'(err_format), r.fmt);
        chk({nm, " err_timeout"}, int'(err_timeout), r.tmo);
        chk({nm, " drain"}, drain, r.drain);
        chk({nm, " passthru"}, pt, 0);
        chk({nm, " tready"}, viol, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        left[0] = 0; left[1] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        row_t r6;
        int t;
        rows[0] = '{n0:1, n1:0, skip1:0,  bad:0, hold:0, rnd:0, g_exp:8'h00, ng_exp:1, beats:N,     fd:1, fmt:0, tmo:0, drain:3};
        rows[1] = '{n0:3, n1:3, skip1:0,  bad:0, hold:0, rnd:1, g_exp:8'h15, ng_exp:6, beats:6 * N, fd:6, fmt:0, tmo:0, drain:18};
        rows[2] = '{n0:0, n1:1, skip1:50, bad:0, hold:0, rnd:0, g_exp:8'h01, ng_exp:1, beats:N,     fd:1, fmt:0, tmo:0, drain:3};
        rows[3] = '{n0:1, n1:0, skip1:0,  bad:1, hold:0, rnd:0, g_exp:8'h00, ng_exp:1, beats:N,     fd:1, fmt:1, tmo:0, drain:3};
        rows[4] = '{n0:2, n1:0, skip1:0,  bad:0, hold:1, rnd:0, g_exp:8'h00, ng_exp:2, beats:2 * N, fd:1, fmt:0, tmo:1, drain:TMO + 3};
        r6      = '{n0:1, n1:1, skip1:0,  bad:0, hold:0, rnd:1, g_exp:8'h01, ng_exp:2, beats:2 * N, fd:2, fmt:0, tmo:0, drain:6};
        done_in = 1'b0; m_tready = 1'b1; rnd = 0; badf = 0;
        do_reset();
        chk("reset outputs", int'({busy, grant_id, frame_done, err_timeout, err_format, m_tvalid, m_tuser, m_tlast, m_tdata, s0_tready, s1_tready}), 0);
        @(posedge clk); #1 done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
        chk("done outside drain", int'({frame_done, busy}), 0);
        for (int i = 0; i < 5; i++) begin
            do_reset();
            run(rows[i], $sformatf("row%0d", i));
        end
        do_reset();
        start(r6);
        for (t = 0; t < 500 && beats < 20; t++) tick();
        chk("mid budget", int'(t < 500), 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset", int'({busy, grant_id, frame_done, err_timeout, err_format, m_tvalid, m_tuser, m_tlast, m_tdata}), 0);
        left[0] = 0; left[1] = 0;
        drive();
        @(negedge clk) rst = 1'b0;
        run(r6, "after_rst");
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
